// File: rtl/alu_seq_if.sv
// Request/response bundle for alu_seq.
// The requester drives operands and accepts results (master side).
// The ALU consumes requests and presents results (slave side).
interface alu_seq_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       opcode;
    logic [WIDTH-1:0] operand1;
    logic [WIDTH-1:0] operand2;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] remainder;
    logic [3:0]       flags;

    modport master (
        output in_valid, opcode, operand1, operand2, out_ready,
        input  in_ready, out_valid, result, remainder, flags
    );

    modport slave (
        input  in_valid, opcode, operand1, operand2, out_ready,
        output in_ready, out_valid, result, remainder, flags
    );
endinterface

// File: rtl/alu_seq.sv
// Multi-cycle ALU with valid/ready handshakes on request and result sides.
// Single-cycle ops finish at the accept edge; mul (shift-add, LSB first) and
// div (restoring, MSB first) iterate for WIDTH cycles in BUSY.
// Flags are {divzero, overflow, carry, zero}.
module alu_seq #(
    parameter int WIDTH = 16
) (
    input  logic     clk,
    input  logic     reset,
    alu_seq_if.slave bus
);
    localparam int            CW   = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e               state_q;
    logic                 in_ready_q;
    logic                 out_valid_q;
    logic [CW-1:0]        cnt_q;
    logic                 is_div_q;
    logic [2*WIDTH-1:0]   prod_q;
    logic [2*WIDTH-1:0]   mcand_q;
    logic [WIDTH-1:0]     mplier_q;
    logic [WIDTH-1:0]     rem_q;
    logic [WIDTH-1:0]     quo_q;
    logic [WIDTH-1:0]     divisor_q;
    logic [WIDTH-1:0]     result_q;
    logic [WIDTH-1:0]     remainder_q;
    logic [3:0]           flags_q;

    // Operands as seen on the bus; only used at the accept edge.
    logic [WIDTH-1:0] a_s;
    logic [WIDTH-1:0] b_s;
    logic [WIDTH:0]   sum_s;
    logic [WIDTH:0]   diff_s;

    assign a_s    = bus.operand1;
    assign b_s    = bus.operand2;
    assign sum_s  = {1'b0, a_s} + {1'b0, b_s};
    // Zero-extended subtraction: bit WIDTH is the unsigned borrow.
    assign diff_s = {1'b0, a_s} - {1'b0, b_s};

    logic [WIDTH-1:0] sc_result_d;
    logic             sc_carry_d;
    logic             sc_ovf_d;

    // Single-cycle datapath: result, carry and overflow of the offered request.
    always_comb begin
        sc_result_d = {WIDTH{1'b0}};
        sc_carry_d  = 1'b0;
        sc_ovf_d    = 1'b0;
        case (bus.opcode)
            4'h0: begin
                sc_result_d = sum_s[WIDTH-1:0];
                sc_carry_d  = sum_s[WIDTH];
                sc_ovf_d    = (a_s[WIDTH-1] == b_s[WIDTH-1]) &&
                              (sum_s[WIDTH-1] != a_s[WIDTH-1]);
            end
            4'h1: begin
                sc_result_d = diff_s[WIDTH-1:0];
                sc_carry_d  = diff_s[WIDTH];
                sc_ovf_d    = (a_s[WIDTH-1] != b_s[WIDTH-1]) &&
                              (diff_s[WIDTH-1] != a_s[WIDTH-1]);
            end
            4'h4: begin
                sc_result_d = {a_s[WIDTH-2:0], 1'b0};
                sc_carry_d  = a_s[WIDTH-1];
            end
            4'h5: begin
                sc_result_d = {1'b0, a_s[WIDTH-1:1]};
                sc_carry_d  = a_s[0];
            end
            4'h6: sc_result_d = {a_s[WIDTH-2:0], a_s[WIDTH-1]};
            4'h7: sc_result_d = {a_s[0], a_s[WIDTH-1:1]};
            4'h8: sc_result_d = a_s & b_s;
            4'h9: sc_result_d = a_s | b_s;
            4'hA: sc_result_d = a_s ^ b_s;
            4'hB: sc_result_d = ~(a_s | b_s);
            4'hC: sc_result_d = ~(a_s & b_s);
            4'hD: sc_result_d = ~(a_s ^ b_s);
            4'hE: sc_result_d = {{(WIDTH-1){1'b0}}, (a_s > b_s)};
            4'hF: sc_result_d = {{(WIDTH-1){1'b0}}, (a_s == b_s)};
            default: begin
                sc_result_d = {WIDTH{1'b0}};
                sc_carry_d  = 1'b0;
                sc_ovf_d    = 1'b0;
            end
        endcase
    end

    // One iteration of each multi-cycle algorithm, applied every BUSY cycle.
    logic [2*WIDTH-1:0] mul_prod_d;
    logic [WIDTH:0]     div_part_s;
    logic               div_ge_s;
    logic [WIDTH-1:0]   div_trial_s;
    logic [WIDTH-1:0]   div_rem_d;
    logic [WIDTH-1:0]   div_quo_d;

    assign mul_prod_d  = mplier_q[0] ? (prod_q + mcand_q) : prod_q;
    // Partial remainder with the next dividend bit shifted in.
    assign div_part_s  = {rem_q, quo_q[WIDTH-1]};
    assign div_ge_s    = (div_part_s >= {1'b0, divisor_q});
    // When div_ge_s holds the true difference is below divisor, so WIDTH bits suffice.
    assign div_trial_s = div_part_s[WIDTH-1:0] - divisor_q;
    assign div_rem_d   = div_ge_s ? div_trial_s : div_part_s[WIDTH-1:0];
    assign div_quo_d   = {quo_q[WIDTH-2:0], div_ge_s};

    // Control FSM plus all datapath and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            cnt_q       <= {CW{1'b0}};
            is_div_q    <= 1'b0;
            prod_q      <= {(2*WIDTH){1'b0}};
            mcand_q     <= {(2*WIDTH){1'b0}};
            mplier_q    <= {WIDTH{1'b0}};
            rem_q       <= {WIDTH{1'b0}};
            quo_q       <= {WIDTH{1'b0}};
            divisor_q   <= {WIDTH{1'b0}};
            result_q    <= {WIDTH{1'b0}};
            remainder_q <= {WIDTH{1'b0}};
            flags_q     <= 4'b0000;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        in_ready_q <= 1'b0;
                        cnt_q      <= {CW{1'b0}};
                        if (bus.opcode == 4'h2) begin
                            state_q  <= S_BUSY;
                            is_div_q <= 1'b0;
                            prod_q   <= {(2*WIDTH){1'b0}};
                            mcand_q  <= {{WIDTH{1'b0}}, a_s};
                            mplier_q <= b_s;
                        end else if ((bus.opcode == 4'h3) && (b_s != {WIDTH{1'b0}})) begin
                            state_q   <= S_BUSY;
                            is_div_q  <= 1'b1;
                            rem_q     <= {WIDTH{1'b0}};
                            quo_q     <= a_s;
                            divisor_q <= b_s;
                        end else if (bus.opcode == 4'h3) begin
                            // Divide by zero short-circuits straight to DONE.
                            state_q     <= S_DONE;
                            out_valid_q <= 1'b1;
                            result_q    <= {WIDTH{1'b1}};
                            remainder_q <= a_s;
                            flags_q     <= 4'b1000;
                        end else begin
                            state_q     <= S_DONE;
                            out_valid_q <= 1'b1;
                            result_q    <= sc_result_d;
                            remainder_q <= {WIDTH{1'b0}};
                            flags_q     <= {1'b0, sc_ovf_d, sc_carry_d,
                                            (sc_result_d == {WIDTH{1'b0}})};
                        end
                    end
                end
                S_BUSY: begin
                    cnt_q <= cnt_q + {{(CW-1){1'b0}}, 1'b1};
                    if (is_div_q) begin
                        rem_q <= div_rem_d;
                        quo_q <= div_quo_d;
                    end else begin
                        prod_q   <= mul_prod_d;
                        mcand_q  <= {mcand_q[2*WIDTH-2:0], 1'b0};
                        mplier_q <= {1'b0, mplier_q[WIDTH-1:1]};
                    end
                    if (cnt_q == LAST) begin
                        state_q     <= S_DONE;
                        out_valid_q <= 1'b1;
                        if (is_div_q) begin
                            result_q    <= div_quo_d;
                            remainder_q <= div_rem_d;
                            flags_q     <= {3'b000, (div_quo_d == {WIDTH{1'b0}})};
                        end else begin
                            result_q    <= mul_prod_d[WIDTH-1:0];
                            remainder_q <= {WIDTH{1'b0}};
                            flags_q     <= {2'b00,
                                            (mul_prod_d[2*WIDTH-1:WIDTH] != {WIDTH{1'b0}}),
                                            (mul_prod_d[WIDTH-1:0] == {WIDTH{1'b0}})};
                        end
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        state_q     <= S_IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    cnt_q       <= {CW{1'b0}};
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.remainder = remainder_q;
    assign bus.flags     = flags_q;
endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: a 16-bit and an 8-bit instance, directed
// cases followed by random traffic with random result back-pressure.
module tb_alu_seq;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    alu_seq_if #(.WIDTH(16)) bif16 ();
    alu_seq_if #(.WIDTH(8))  bif8  ();

    alu_seq #(.WIDTH(16)) u16 (.clk(clk), .reset(reset), .bus(bif16));
    alu_seq #(.WIDTH(8))  u8  (.clk(clk), .reset(reset), .bus(bif8));

    typedef struct {
        logic [63:0] res;
        logic [63:0] rem;
        logic [3:0]  flg;
        int          lat;
        int          acc;
    } exp_t;

    exp_t q16[$];
    exp_t q8[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    bit   rdy_rand = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Behavioural reference: plain arithmetic on masked integers.
    function automatic exp_t model(input int w, input logic [3:0] op,
                                   input logic [63:0] a_in, input logic [63:0] b_in);
        exp_t        e;
        logic [63:0] m, a, b, r, rm;
        logic [127:0] p;
        logic        cy, ov, dz;
        longint      sa, sb, s, lim;
        m  = (64'd1 << w) - 64'd1;
        a  = a_in & m;
        b  = b_in & m;
        r  = 64'd0; rm = 64'd0; cy = 1'b0; ov = 1'b0; dz = 1'b0;
        e.lat = 1;
        e.acc = 0;
        case (op)
            4'h0: begin p = {64'd0, a} + {64'd0, b}; r = p[63:0] & m; cy = ((p >> w) != 128'd0); end
            4'h1: begin r = (a - b) & m; cy = (a < b); end
            4'h2: begin p = {64'd0, a} * {64'd0, b}; r = p[63:0] & m; cy = ((p >> w) != 128'd0); e.lat = w + 1; end
            4'h3: begin
                if (b == 64'd0) begin r = m; rm = a; dz = 1'b1; end
                else begin r = a / b; rm = a % b; e.lat = w + 1; end
            end
            4'h4: begin r = (a << 1) & m; cy = a[w-1]; end
            4'h5: begin r = a >> 1; cy = a[0]; end
            4'h6: r = ((a << 1) | (a >> (w - 1))) & m;
            4'h7: r = (a >> 1) | ((a & 64'd1) << (w - 1));
            4'h8: r = a & b;
            4'h9: r = a | b;
            4'hA: r = a ^ b;
            4'hB: r = ~(a | b) & m;
            4'hC: r = ~(a & b) & m;
            4'hD: r = ~(a ^ b) & m;
            4'hE: r = (a > b) ? 64'd1 : 64'd0;
            default: r = (a == b) ? 64'd1 : 64'd0;
        endcase
        if (op == 4'h0 || op == 4'h1) begin
            sa  = a[w-1] ? longint'(a) - (longint'(1) <<< w) : longint'(a);
            sb  = b[w-1] ? longint'(b) - (longint'(1) <<< w) : longint'(b);
            s   = (op == 4'h0) ? sa + sb : sa - sb;
            lim = longint'(1) <<< (w - 1);
            ov  = (s >= lim) || (s < -lim);
        end
        e.res = r;
        e.rem = rm;
        e.flg = {dz, ov, cy, (r == 64'd0)};
        return e;
    endfunction

    function automatic logic [63:0] pick(input int w);
        logic [63:0] m, v;
        m = (64'd1 << w) - 64'd1;
        case ($urandom_range(0, 5))
            0: v = 64'd0;
            1: v = m;
            2: v = 64'd1 << (w - 1);
            3: v = 64'($urandom_range(0, 15));
            default: v = {32'($urandom), 32'($urandom)};
        endcase
        return v & m;
    endfunction

    // Issue one request; called and returns at posedge+#1.
    task automatic issue(input int sel, input logic [3:0] op,
                         input logic [63:0] a, input logic [63:0] b, input bit push);
        int   t;
        exp_t e;
        t = 0;
        while (((sel == 0) ? bif16.in_ready : bif8.in_ready) !== 1'b1 && t < 300) begin
            @(posedge clk); #1;
            t++;
        end
        chk("accept_wait_in_bound", 64'(t < 300), 64'd1);
        e     = model((sel == 0) ? 16 : 8, op, a, b);
        e.acc = cyc;
        if (sel == 0) begin
            bif16.in_valid = 1'b1; bif16.opcode = op;
            bif16.operand1 = a[15:0]; bif16.operand2 = b[15:0];
            if (push) q16.push_back(e);
        end else begin
            bif8.in_valid = 1'b1; bif8.opcode = op;
            bif8.operand1 = a[7:0]; bif8.operand2 = b[7:0];
            if (push) q8.push_back(e);
        end
        @(posedge clk); #1;
        if (sel == 0) begin
            bif16.in_valid = 1'b0;
            bif16.operand1 = 16'($urandom); bif16.operand2 = 16'($urandom);
        end else begin
            bif8.in_valid = 1'b0;
            bif8.operand1 = 8'($urandom); bif8.operand2 = 8'($urandom);
        end
    endtask

    // Wait for out_valid on the 16-bit instance, checking in_ready stays low.
    task automatic wait_valid16(input string name);
        int t, bad;
        t = 0; bad = 0;
        while (bif16.out_valid !== 1'b1 && t < 100) begin
            if (bif16.in_ready !== 1'b0) bad++;
            @(posedge clk); #1;
            t++;
        end
        chk({name, "_in_ready_low"}, 64'(bad), 64'd0);
        chk({name, "_valid_seen"}, 64'(bif16.out_valid), 64'd1);
    endtask

    task automatic monitor(input int sel);
        bit          prev, v, rd;
        logic [63:0] res, rem;
        logic [3:0]  flg;
        exp_t        e;
        int          qs;
        string       tag;
        prev = 1'b0;
        tag  = (sel == 0) ? "w16" : "w8";
        forever begin
            @(negedge clk);
            if (sel == 0) begin
                v = bif16.out_valid; rd = bif16.out_ready;
                res = 64'(bif16.result); rem = 64'(bif16.remainder);
                flg = bif16.flags; qs = q16.size();
            end else begin
                v = bif8.out_valid; rd = bif8.out_ready;
                res = 64'(bif8.result); rem = 64'(bif8.remainder);
                flg = bif8.flags; qs = q8.size();
            end
            if (v && !prev) begin
                chk({tag, "_result_expected"}, 64'(qs != 0), 64'd1);
                if (qs != 0) begin
                    e = (sel == 0) ? q16[0] : q8[0];
                    chk({tag, "_latency"}, 64'(cyc - e.acc), 64'(e.lat));
                end
            end
            if (v && rd && qs != 0) begin
                if (sel == 0) e = q16.pop_front();
                else          e = q8.pop_front();
                chk({tag, "_result"},    res,        e.res);
                chk({tag, "_remainder"}, rem,        e.rem);
                chk({tag, "_flags"},     64'(flg),   64'(e.flg));
            end
            prev = v;
        end
    endtask

    initial begin
        int t;
        reset = 1'b1;
        bif16.in_valid = 1'b0; bif16.opcode = 4'h0; bif16.operand1 = 16'h0;
        bif16.operand2 = 16'h0; bif16.out_ready = 1'b1;
        bif8.in_valid = 1'b0; bif8.opcode = 4'h0; bif8.operand1 = 8'h0;
        bif8.operand2 = 8'h0; bif8.out_ready = 1'b1;

        fork
            monitor(0);
            monitor(1);
            forever begin
                @(posedge clk); #1;
                if (rdy_rand) begin
                    bif16.out_ready = ($urandom_range(0, 3) != 0);
                    bif8.out_ready  = ($urandom_range(0, 3) != 0);
                end
            end
        join_none

        repeat (3) @(posedge clk);
        #1;
        chk("reset_in_ready",  64'(bif16.in_ready),  64'd1);
        chk("reset_out_valid", 64'(bif16.out_valid), 64'd0);
        chk("reset_result",    64'(bif16.result),    64'd0);
        chk("reset_remainder", 64'(bif16.remainder), 64'd0);
        chk("reset_flags",     64'(bif16.flags),     64'd0);
        reset = 1'b0;

        // Directed cases on the 16-bit instance.
        issue(0, 4'h0, 64'hFFFF, 64'h0001, 1'b1);
        issue(0, 4'h0, 64'h7FFF, 64'h0001, 1'b1);
        issue(0, 4'h2, 64'h0123, 64'h0045, 1'b1);
        wait_valid16("mul_busy");
        issue(0, 4'h2, 64'h0100, 64'h0100, 1'b1);
        issue(0, 4'h3, 64'h03E8, 64'h0007, 1'b1);
        issue(0, 4'h3, 64'h1234, 64'h0000, 1'b1);
        issue(0, 4'h1, 64'h0001, 64'h0002, 1'b1);
        issue(0, 4'hE, 64'h8000, 64'h7FFF, 1'b1);

        // Back-pressure: result must hold, stray requests must be ignored.
        @(posedge clk); #1;
        bif16.out_ready = 1'b0;
        issue(0, 4'h4, 64'h8001, 64'h0000, 1'b1);
        for (int i = 0; i < 5; i++) begin
            chk("bp_result", 64'(bif16.result),   64'h0002);
            chk("bp_carry",  64'(bif16.flags[1]), 64'd1);
            chk("bp_in_ready_low", 64'(bif16.in_ready), 64'd0);
            bif16.in_valid = 1'b1; bif16.opcode = 4'h9;
            bif16.operand1 = 16'h1111; bif16.operand2 = 16'h2222;
            @(posedge clk); #1;
            bif16.in_valid = 1'b0;
        end
        bif16.out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_idle_in_ready",  64'(bif16.in_ready),  64'd1);
        chk("bp_idle_out_valid", 64'(bif16.out_valid), 64'd0);

        // Reset in the middle of a divide drops it without output.
        issue(0, 4'h3, 64'h9999, 64'h0007, 1'b0);
        repeat (4) begin @(posedge clk); #1; end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("rst_mid_out_valid", 64'(bif16.out_valid), 64'd0);
        chk("rst_mid_in_ready",  64'(bif16.in_ready),  64'd1);
        chk("rst_mid_result",    64'(bif16.result),    64'd0);
        chk("rst_mid_flags",     64'(bif16.flags),     64'd0);
        issue(0, 4'h8, 64'h00F0, 64'h0FF0, 1'b1);
        repeat (20) @(posedge clk);
        #1;

        // Directed cases on the 8-bit instance.
        issue(1, 4'h2, 64'h10, 64'h10, 1'b1);
        issue(1, 4'h7, 64'h01, 64'h00, 1'b1);
        issue(1, 4'h3, 64'hC8, 64'h0D, 1'b1);

        // Random traffic on both instances with random back-pressure.
        rdy_rand = 1'b1;
        fork
            for (int i = 0; i < 200; i++) begin
                logic [3:0] op16;
                op16 = 4'($urandom_range(0, 15));
                issue(0, op16, pick(16), ((op16 == 4'h3) && ($urandom_range(0, 7) == 0)) ? 64'd0 : pick(16), 1'b1);
            end
            for (int j = 0; j < 120; j++) begin
                logic [3:0] op8;
                op8 = 4'($urandom_range(0, 15));
                issue(1, op8, pick(8), ((op8 == 4'h3) && ($urandom_range(0, 7) == 0)) ? 64'd0 : pick(8), 1'b1);
            end
        join
        rdy_rand = 1'b0;
        bif16.out_ready = 1'b1;
        bif8.out_ready  = 1'b1;
        t = 0;
        while ((q16.size() != 0 || q8.size() != 0) && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        chk("drain_queues_empty", 64'(q16.size() + q8.size()), 64'd0);
        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised multi-cycle ALU with a valid/ready handshake on both sides. It replaces the purely combinational 16-bit ALU between the accumulator/operand registers and the result path of the processor datapath. It keeps the same 4-bit opcode map and adds:
- width generalisation;
- status flags;
- iterative (shift-add / restoring) multiply and divide with a remainder output;
- registered, back-pressurable results.

## Interface
- WIDTH, 16, operand/result width in bits; legal range 4..64.
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high; wins over all other inputs.
- in_valid  in  1  request present on opcode/operand1/operand2.
- in_ready  out  1  block can accept a request; high only in IDLE.
- opcode  in  4  operation select.
- operand1  in  WIDTH  first operand (unsigned unless stated).
- operand2  in  WIDTH  second operand.
- out_valid  out  1  result, remainder and flags are valid.
- out_ready  in  1  consumer accepts the result.
- result  out  WIDTH  registered result.
- remainder  out  WIDTH  division remainder; 0 for all other ops.
- flags  out  4  {divzero, overflow, carry, zero}.

## Operation
- States:
  - IDLE: in_ready=1.
  - BUSY: iterative multiply or divide.
  - DONE: out_valid=1.
- Accept occurs on a clk edge with in_valid & in_ready. Opcode and operands are captured at that edge; later input changes are ignored until the next accept.
- Opcodes:
  - 0 add, 1 sub, 2 mul, 3 div.
  - 4 shl by 1, 5 shr by 1 (logical), 6 rotl by 1, 7 rotr by 1.
  - 8 and, 9 or, A xor, B nor, C nand, D xnor.
  - E unsigned greater-than (result 1/0), F equal (result 1/0).
- Single-cycle ops (all except 2 and 3, plus divide by zero): IDLE -> DONE at the accept edge.
- mul: IDLE -> BUSY. Shift-add over WIDTH iterations, one bit of operand2 per cycle, LSB first. result = low WIDTH bits of the 2*WIDTH product.
- div: IDLE -> BUSY. Unsigned restoring division over WIDTH iterations, one quotient bit per cycle, MSB first. result = quotient, remainder = remainder.
- div with operand2==0: no BUSY. result = all ones, remainder = operand1, divzero=1.
- BUSY -> DONE when the iteration counter reaches WIDTH-1. The counter is log2(WIDTH)+1 bits wide.
- DONE -> IDLE on a clk edge with out_ready=1. result, remainder and flags hold stable while out_valid=1 and out_ready=0.
- Flags:
  - zero: result==0, for every op.
  - carry: add carry-out; sub borrow (operand1<operand2); shl operand1[WIDTH-1]; shr operand1[0]; mul high half of product !=0; 0 for all other ops.
  - overflow: signed two's-complement overflow for add/sub only; 0 otherwise.
  - divzero: div with operand2==0 only.
- Reset:
  - state=IDLE, in_ready=1, out_valid=0, result=0, remainder=0, flags=0, counter=0.
  - Reset during BUSY or DONE discards the in-flight operation with no output.

## Timing
- Single-cycle ops and divide by zero: out_valid rises 1 cycle after the accept edge.
- mul/div: out_valid rises WIDTH+1 cycles after the accept edge (17 for WIDTH=16).
- in_ready is low from the accept edge until the cycle after the output handshake.
- Minimum request spacing: 2 cycles for single-cycle ops; WIDTH+2 cycles for mul/div.
- A new request cannot be accepted in the same cycle as the output handshake.
- All outputs are registered or decoded from state. There is no combinational path from any input to any output.
- reset asserted on the same edge as in_valid: reset wins and the request is not accepted.

## Test plan
- add, WIDTH=16:
  - 0xFFFF+0x0001 -> result 0x0000, flags {0,0,1,1}, out_valid exactly 1 cycle after accept.
  - 0x7FFF+0x0001 -> result 0x8000, overflow=1, carry=0.
- mul:
  - 0x0123*0x0045 -> result 0x4E6F, carry=0, out_valid at accept+17, in_ready low throughout.
  - 0x0100*0x0100 -> result 0x0000, carry=1, zero=1.
- div:
  - 0x03E8/0x0007 -> result 0x008E, remainder 0x0006, at accept+17.
  - 0x1234/0x0000 -> result 0xFFFF, remainder 0x1234, divzero=1, at accept+1.
- Back-pressure: shl 0x8001 with out_ready held low 5 cycles.
  - result 0x0002 and carry=1 stay stable throughout.
  - in_valid pulses in that window are not accepted.
  - out_ready=1 -> IDLE next cycle.
- Reset mid-op: assert reset at BUSY cycle 5 of a div.
  - Next cycle: out_valid=0, in_ready=1, result=0, flags=0.
  - A following and 0x00F0&0x0FF0 -> result 0x00F0.
- WIDTH=8 instance: mul 0x10*0x10 -> result 0x00, carry=1, out_valid at accept+9. rotr 0x01 -> 0x80.
